// File: rtl/paddle_axis_emu.sv
// -----------------------------------------------------------------------------
// paddle_axis_emu
//
// Turns PS/2 mouse motion into an analog paddle/stick position on one of NCH
// controller ports. Every other port passes its HPS analog joystick and fire
// buttons straight through. The mouse-owned port keeps a saturating signed
// accumulator per axis that each mouse packet nudges by a clamped and shifted
// step. Touching the real joystick on a port, halting the CPU or moving the
// mouse to another port hands that port back to the joystick. An optional
// prescaled decay pulls the emulated position back towards centre.
//
// Ports:
//   CLK_VIDEO   in   1         clock
//   areset      in   1         synchronous active-high reset
//   ps2_mouse   in   25        hps_io mouse packet: [24] toggle strobe,
//                              [23:16] dy, [15:8] dx, [5:4] Y/X sign,
//                              [1:0] buttons
//   mouse_sel   in   SW        port currently driven by the mouse
//   joya        in   NCH*16    analog stick per port: [15:8] Y, [7:0] X
//   joy_btn     in   NCH*2     digital fire buttons per port
//   halt        in   1         CPU halted; drops all emulation
//   decay_en    in   1         enables auto-centre decay
//   out_x       out  NCH*AW    X axis per port, signed
//   out_y       out  NCH*AW    Y axis per port, signed
//   out_btn     out  NCH*2     fire buttons per port
//   emu_active  out  NCH       port is currently owned by the mouse
// -----------------------------------------------------------------------------
module paddle_axis_emu #(
    parameter int NCH       = 2,
    parameter int AW        = 8,
    parameter int SHIFT     = 1,
    parameter int STEP_MAX  = 10,
    parameter int DECAY_DIV = 0
) (
    input  logic                                       CLK_VIDEO,
    input  logic                                       areset,
    input  logic [24:0]                                ps2_mouse,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]   mouse_sel,
    input  logic [NCH*16-1:0]                          joya,
    input  logic [NCH*2-1:0]                           joy_btn,
    input  logic                                       halt,
    input  logic                                       decay_en,
    output logic [NCH*AW-1:0]                          out_x,
    output logic [NCH*AW-1:0]                          out_y,
    output logic [NCH*2-1:0]                           out_btn,
    output logic [NCH-1:0]                             emu_active
);

    localparam int SW = $bits(mouse_sel);

    // Saturation limits of an AW-bit signed axis, held in the AW+2-bit sum width.
    localparam logic signed [AW+1:0] SAT_HI   = (AW+2)'((1 << (AW-1)) - 1);
    localparam logic signed [AW+1:0] SAT_LO   = (AW+2)'(-(1 << (AW-1)));
    // Per-packet step clamp, in the 9-bit width of the raw PS/2 delta.
    localparam logic signed [8:0]    STEP_HI  = 9'(STEP_MAX);
    localparam logic signed [8:0]    STEP_LO  = 9'(-STEP_MAX);
    localparam logic signed [AW:0]   ACC_ONE  = (AW+1)'(1);

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Raw PS/2 delta {sign, byte} -> shifted, clamped step in sum width.
    function automatic logic signed [AW+1:0] step_delta(input logic       sgn,
                                                        input logic [7:0] mag);
        logic signed [8:0] raw;
        logic signed [8:0] shd;
        raw = {sgn, mag};
        shd = raw >>> SHIFT;
        if (shd > STEP_HI) begin
            shd = STEP_HI;
        end else if (shd < STEP_LO) begin
            shd = STEP_LO;
        end
        return (AW+2)'(shd);
    endfunction

    // Accumulator plus step, saturated to the AW-bit signed range.
    function automatic logic signed [AW:0] sat_add(input logic signed [AW:0]   acc,
                                                   input logic signed [AW+1:0] d);
        logic signed [AW+1:0] sum;
        sum = (AW+2)'(acc) + d;
        if (sum > SAT_HI) begin
            sum = SAT_HI;
        end else if (sum < SAT_LO) begin
            sum = SAT_LO;
        end
        return sum[AW:0];
    endfunction

    // One decay step: move one count towards zero, zero stays zero.
    function automatic logic signed [AW:0] toward_zero(input logic signed [AW:0] acc);
        if (acc == '0) begin
            return acc;
        end else if (acc[AW]) begin
            return acc + ACC_ONE;
        end else begin
            return acc - ACC_ONE;
        end
    endfunction

    // 8-bit signed joystick axis, sign-extended or truncated to AW.
    function automatic logic [AW-1:0] ext_axis(input logic [7:0] v);
        return AW'(signed'(v));
    endfunction

    // -------------------------------------------------------------------------
    // Input views
    // -------------------------------------------------------------------------
    logic [NCH-1:0][15:0] joy_w;
    logic [NCH-1:0][1:0]  btn_w;

    assign joy_w = joya;
    assign btn_w = joy_btn;

    // Packet bits 7:6 (overflow) and 3:2 (middle button / always-1) carry
    // nothing this block acts on.
    logic unused_ps2;
    assign unused_ps2 = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

    // -------------------------------------------------------------------------
    // Decay prescaler
    // -------------------------------------------------------------------------
    logic decay_tick;

    if (DECAY_DIV > 0) begin : g_decay
        localparam int            PW       = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
        localparam logic [PW-1:0] PRE_LAST = PW'(DECAY_DIV - 1);

        logic [PW-1:0] pre_q;

        // Holds at zero while disabled so every enable starts a full period.
        always_ff @(posedge CLK_VIDEO) begin
            if (areset || !decay_en) begin
                pre_q <= '0;
            end else if (pre_q == PRE_LAST) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_q + PW'(1);
            end
        end

        assign decay_tick = decay_en && (pre_q == PRE_LAST);
    end else begin : g_no_decay
        logic unused_decay;
        assign unused_decay = decay_en;
        assign decay_tick   = 1'b0;
    end

    // -------------------------------------------------------------------------
    // Emulation state
    // -------------------------------------------------------------------------
    logic                  stb_q;
    logic [SW-1:0]         sel_q;
    logic [NCH-1:0]        emu_q,   emu_d;
    logic signed [AW:0]    acc_x_q [NCH];
    logic signed [AW:0]    acc_x_d [NCH];
    logic signed [AW:0]    acc_y_q [NCH];
    logic signed [AW:0]    acc_y_d [NCH];

    logic                  evt;
    logic                  sel_chg;
    logic signed [AW+1:0]  dx_step;
    logic signed [AW+1:0]  dy_step;
    logic [NCH-1:0]        port_clr;
    logic [NCH-1:0]        port_hit;

    // NOTE: every signal written here gets a value before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        evt      = (ps2_mouse[24] != stb_q);
        sel_chg  = (mouse_sel != sel_q);
        dx_step  = step_delta(ps2_mouse[4], ps2_mouse[15:8]);
        dy_step  = step_delta(ps2_mouse[5], ps2_mouse[23:16]);
        emu_d    = emu_q;
        port_clr = '0;
        port_hit = '0;

        for (int p = 0; p < NCH; p++) begin
            acc_x_d[p] = acc_x_q[p];
            acc_y_d[p] = acc_y_q[p];

            // A live joystick, a halted CPU, or the mouse leaving this port
            // all return the port to the joystick.
            port_clr[p] = (joy_w[p] != 16'h0000) || halt
                        || (sel_chg && (sel_q == SW'(p)));
            // Out-of-range selects match no port, so their events vanish.
            port_hit[p] = evt && (mouse_sel == SW'(p));

            if (port_clr[p]) begin
                emu_d[p]   = 1'b0;
                acc_x_d[p] = '0;
                acc_y_d[p] = '0;
            end else if (port_hit[p]) begin
                emu_d[p]   = 1'b1;
                acc_x_d[p] = sat_add(acc_x_q[p], dx_step);
                acc_y_d[p] = sat_add(acc_y_q[p], dy_step);
            end else if (decay_tick && emu_q[p]) begin
                acc_x_d[p] = toward_zero(acc_x_q[p]);
                acc_y_d[p] = toward_zero(acc_y_q[p]);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK_VIDEO) begin
        // The strobe and select track their inputs even in reset, so the
        // first edge after release sees no phantom toggle or port change.
        stb_q <= ps2_mouse[24];
        sel_q <= mouse_sel;
        if (areset) begin
            emu_q <= '0;
            // NOTE: the accumulators are a handful of flops, not a RAM, so
            // resetting them costs nothing and keeps the state deterministic.
            for (int p = 0; p < NCH; p++) begin
                acc_x_q[p] <= '0;
                acc_y_q[p] <= '0;
            end
        end else begin
            emu_q <= emu_d;
            for (int p = 0; p < NCH; p++) begin
                acc_x_q[p] <= acc_x_d[p];
                acc_y_q[p] <= acc_y_d[p];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output register: one cycle behind the state update
    // -------------------------------------------------------------------------
    logic [NCH-1:0][AW-1:0] out_x_q;
    logic [NCH-1:0][AW-1:0] out_y_q;
    logic [NCH-1:0][1:0]    out_btn_q;
    logic [NCH-1:0]         emu_active_q;

    always_ff @(posedge CLK_VIDEO) begin
        if (areset) begin
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_btn_q    <= '0;
            emu_active_q <= '0;
        end else begin
            for (int p = 0; p < NCH; p++) begin
                if (emu_q[p]) begin
                    out_x_q[p]   <= acc_x_q[p][AW-1:0];
                    out_y_q[p]   <= acc_y_q[p][AW-1:0];
                    out_btn_q[p] <= ps2_mouse[1:0];
                end else begin
                    out_x_q[p]   <= ext_axis(joy_w[p][7:0]);
                    out_y_q[p]   <= ext_axis(joy_w[p][15:8]);
                    out_btn_q[p] <= btn_w[p];
                end
            end
            emu_active_q <= emu_q;
        end
    end

    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_btn    = out_btn_q;
    assign emu_active = emu_active_q;

endmodule

// File: tb/tb_paddle_axis_emu.sv
// -----------------------------------------------------------------------------
// tb_paddle_axis_emu
//
// Directed bench for paddle_axis_emu (NCH=2, AW=8, SHIFT=1, STEP_MAX=10,
// DECAY_DIV=4). A behavioural model of the mouse/joystick ownership rules
// predicts every output on every cycle; a few hand-computed values pin the
// model at the interesting points of the sequence.
// -----------------------------------------------------------------------------
module tb_paddle_axis_emu;

    localparam int NCH       = 2;
    localparam int AW        = 8;
    localparam int SHIFT     = 1;
    localparam int STEP_MAX  = 10;
    localparam int DECAY_DIV = 4;
    localparam int AXIS_MAX  = (1 << (AW-1)) - 1;
    localparam int AXIS_MIN  = -(1 << (AW-1));

    logic               clk = 1'b0;
    logic               areset;
    logic [24:0]        ps2;
    logic               mouse_sel;
    logic [NCH*16-1:0]  joya;
    logic [NCH*2-1:0]   joy_btn;
    logic               halt;
    logic               decay_en;
    logic [NCH*AW-1:0]  out_x;
    logic [NCH*AW-1:0]  out_y;
    logic [NCH*2-1:0]   out_btn;
    logic [NCH-1:0]     emu_active;

    always #5 clk = ~clk;

    paddle_axis_emu #(
        .NCH       (NCH),
        .AW        (AW),
        .SHIFT     (SHIFT),
        .STEP_MAX  (STEP_MAX),
        .DECAY_DIV (DECAY_DIV)
    ) dut (
        .CLK_VIDEO  (clk),
        .areset     (areset),
        .ps2_mouse  (ps2),
        .mouse_sel  (mouse_sel),
        .joya       (joya),
        .joy_btn    (joy_btn),
        .halt       (halt),
        .decay_en   (decay_en),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_btn    (out_btn),
        .emu_active (emu_active)
    );

    // -------------------------------------------------------------------------
    // Scoring
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    // Mouse step: floor(raw / 2^SHIFT), then limited to +/-STEP_MAX.
    function automatic int mdelta(input logic sgn, input logic [7:0] mag);
        int raw;
        int div;
        int d;
        div = 1 << SHIFT;
        raw = sgn ? int'(mag) - 256 : int'(mag);
        d   = (raw >= 0) ? raw / div : -((-raw + div - 1) / div);
        if (d > STEP_MAX)  d = STEP_MAX;
        if (d < -STEP_MAX) d = -STEP_MAX;
        return d;
    endfunction

    function automatic int sat(input int v);
        return (v > AXIS_MAX) ? AXIS_MAX : (v < AXIS_MIN) ? AXIS_MIN : v;
    endfunction

    function automatic int to_centre(input int v);
        return (v > 0) ? v - 1 : (v < 0) ? v + 1 : 0;
    endfunction

    int m_acc_x [NCH];
    int m_acc_y [NCH];
    bit m_emu   [NCH];
    bit m_stb;
    int m_sel;
    int m_pre;
    int e_x   [NCH];
    int e_y   [NCH];
    int e_btn [NCH];
    int e_emu;
    bit model_ok = 1'b0;

    always @(posedge clk) begin : model
        int dx;
        int dy;
        bit evt;
        bit chg;
        bit tick;
        bit clr;
        bit hit;
        if (areset) begin
            for (int p = 0; p < NCH; p++) begin
                m_acc_x[p] = 0;
                m_acc_y[p] = 0;
                m_emu[p]   = 1'b0;
                e_x[p]     = 0;
                e_y[p]     = 0;
                e_btn[p]   = 0;
            end
            e_emu    = 0;
            m_stb    = ps2[24];
            m_sel    = int'(mouse_sel);
            m_pre    = 0;
            model_ok = 1'b1;
        end else begin
            // Outputs show the state as it stood before this edge.
            e_emu = 0;
            for (int p = 0; p < NCH; p++) begin
                e_x[p]   = m_emu[p] ? m_acc_x[p] : int'($signed(joya[p*16 +: 8]));
                e_y[p]   = m_emu[p] ? m_acc_y[p] : int'($signed(joya[p*16+8 +: 8]));
                e_btn[p] = m_emu[p] ? int'(ps2[1:0]) : int'(joy_btn[p*2 +: 2]);
                if (m_emu[p]) e_emu += (1 << p);
            end

            evt   = (ps2[24] != m_stb);
            chg   = (int'(mouse_sel) != m_sel);
            tick  = decay_en && (m_pre == DECAY_DIV - 1);
            m_pre = decay_en ? (m_pre + 1) % DECAY_DIV : 0;
            dx    = mdelta(ps2[4], ps2[15:8]);
            dy    = mdelta(ps2[5], ps2[23:16]);

            for (int p = 0; p < NCH; p++) begin
                clr = (joya[p*16 +: 16] != 16'h0) || halt || (chg && p == m_sel);
                hit = evt && (p == int'(mouse_sel));
                if (clr) begin
                    m_emu[p]   = 1'b0;
                    m_acc_x[p] = 0;
                    m_acc_y[p] = 0;
                end else if (hit) begin
                    m_emu[p]   = 1'b1;
                    m_acc_x[p] = sat(m_acc_x[p] + dx);
                    m_acc_y[p] = sat(m_acc_y[p] + dy);
                end else if (tick && m_emu[p]) begin
                    m_acc_x[p] = to_centre(m_acc_x[p]);
                    m_acc_y[p] = to_centre(m_acc_y[p]);
                end
            end
            m_stb = ps2[24];
            m_sel = int'(mouse_sel);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            for (int p = 0; p < NCH; p++) begin
                check($sformatf("out_x[%0d]", p),   int'($signed(out_x[p*AW +: AW])), e_x[p]);
                check($sformatf("out_y[%0d]", p),   int'($signed(out_y[p*AW +: AW])), e_y[p]);
                check($sformatf("out_btn[%0d]", p), int'(out_btn[p*2 +: 2]),         e_btn[p]);
            end
            check("emu_active", int'(emu_active), e_emu);
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    // Present one mouse packet (strobe toggle) for one edge.
    task automatic send(input int dx, input int dy);
        ps2[15:8]  = 8'(dx);
        ps2[4]     = (dx < 0);
        ps2[23:16] = 8'(dy);
        ps2[5]     = (dy < 0);
        ps2[24]    = ~ps2[24];
        @(negedge clk);
    endtask

    function automatic int ax(input logic [NCH*AW-1:0] bus, input int p);
        return int'($signed(bus[p*AW +: AW]));
    endfunction

    initial begin
        areset    = 1'b1;
        ps2       = '0;
        ps2[1:0]  = 2'b01;
        mouse_sel = 1'b0;
        joya      = '0;
        joy_btn   = 4'b1110;
        halt      = 1'b0;
        decay_en  = 1'b0;

        repeat (2) @(negedge clk);
        check("reset out_x",      int'(out_x),      0);
        check("reset out_y",      int'(out_y),      0);
        check("reset out_btn",    int'(out_btn),    0);
        check("reset emu_active", int'(emu_active), 0);

        areset       = 1'b0;
        joya[31:16]  = 16'hFD07;           // port 1 stick: Y=-3, X=+7
        @(negedge clk);

        // First packet: 100 >> 1 = 50, clamped to 10; visible two edges later.
        send(100, 0);
        @(negedge clk);
        check("first event x0",   ax(out_x, 0), 10);
        check("first event emu",  int'(emu_active), 1);
        check("passthrough x1",   ax(out_x, 1), 7);
        check("passthrough y1",   ax(out_y, 1), -3);
        check("mouse btn0",       int'(out_btn[1:0]), 1);
        check("joy btn1",         int'(out_btn[3:2]), 3);

        // Twelve more: X 130 saturates to 127; Y floor(-7/2) = -4 per packet.
        for (int i = 0; i < 12; i++) send(100, -7);
        @(negedge clk);
        check("saturate x0",      ax(out_x, 0), 127);
        check("floor shift y0",   ax(out_y, 0), -48);

        // 0x80 with sign: -128 >> 1 = -64, clamped to -10.
        send(-128, 0);
        @(negedge clk);
        check("neg clamp x0",     ax(out_x, 0), 117);

        // Halt drops the emulation; rebuild port 0 to 40.
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        for (int i = 0; i < 4; i++) send(100, 0);
        @(negedge clk);
        check("rebuild x0",       ax(out_x, 0), 40);
        check("halt cleared y0",  ax(out_y, 0), 0);

        // Live joystick on port 0 takes it back.
        joya[15:0] = 16'h0005;
        @(negedge clk);
        check("clear lag x0",     ax(out_x, 0), 40);
        @(negedge clk);
        check("joy wins x0",      ax(out_x, 0), 5);
        check("joy wins emu",     int'(emu_active), 0);
        joya[15:0] = 16'h0000;
        @(negedge clk);
        check("joy idle x0",      ax(out_x, 0), 0);

        // Event while halted: clear has priority.
        halt = 1'b1;
        send(20, 0);
        halt = 1'b0;
        @(negedge clk);
        check("halt+evt x0",      ax(out_x, 0), 0);
        check("halt+evt emu",     int'(emu_active), 0);

        // Port switch: port 0 at 30, then move to port 1 with a +40 packet.
        joya[31:16] = 16'h0000;
        for (int i = 0; i < 3; i++) send(100, 0);
        @(negedge clk);
        check("port0 at 30",      ax(out_x, 0), 30);
        mouse_sel = 1'b1;
        send(40, 0);
        @(negedge clk);
        check("switch emu",       int'(emu_active), 2);
        check("switch x0",        ax(out_x, 0), 0);
        check("switch x1",        ax(out_x, 1), 10);

        // Decay every 4 clocks: 10 -> 9 after the 4th edge, 0 after the 40th.
        decay_en = 1'b1;
        repeat (4) @(negedge clk);
        check("decay pre x1",     ax(out_x, 1), 10);
        @(negedge clk);
        check("decay one x1",     ax(out_x, 1), 9);
        repeat (40) @(negedge clk);
        check("decay done x1",    ax(out_x, 1), 0);
        check("decay keeps emu",  int'(emu_active), 2);

        // Reset during a strobe toggle: nothing applied after release.
        ps2[15:8] = 8'd100;
        ps2[4]    = 1'b0;
        ps2[24]   = ~ps2[24];
        areset    = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        repeat (2) @(negedge clk);
        check("post-reset out_x", int'(out_x),      0);
        check("post-reset out_y", int'(out_y),      0);
        check("post-reset emu",   int'(emu_active), 0);
        check("post-reset btn",   int'(out_btn),    14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
